eu_opbuf_mc: RTL and testbench

// Multi-channel operand receive buffer for one exec unit. It accepts operand packets
// (addr+data) from NUM_WR_CH interconnect write channels and stores them in a

---
 rtl/eu_opbuf_mc_pkg.sv | 32 +++
 rtl/eu_opbuf_alloc.sv | 57 +++++
 rtl/eu_opbuf_mc.sv | 103 ++++++++++
 tb/tb_eu_opbuf_mc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/eu_opbuf_mc_pkg.sv
// eu_opbuf_mc_pkg: shared parameters and packet/entry types for the operand buffer
package eu_opbuf_mc_pkg;
  localparam int EU_CACHE_XBUF_NUM_IDX_BITS = 3;
  localparam int OPBUF_NUM_IDX_BITS = EU_CACHE_XBUF_NUM_IDX_BITS;
  localparam int OPBUF_NUM_WR_CH = 2;
  localparam int OPBUF_NUM_RD_CH = 2;
  localparam int OPBUF_ADDR_W = 8;
  localparam int OPBUF_DATA_W = 32;
  typedef struct packed {
    logic                    valid;
    logic [OPBUF_ADDR_W-1:0] addr;
    logic [OPBUF_DATA_W-1:0] data;
  } type_opbuf_entry;
  typedef struct packed {
    logic                    valid;
    logic [OPBUF_ADDR_W-1:0] addr;
    logic [OPBUF_DATA_W-1:0] data;
  } type_opbuf_wr_req;
  typedef struct packed {
    logic                    valid;
    logic [OPBUF_ADDR_W-1:0] addr;
    logic                    consume;
  } type_opbuf_rd_req;
  typedef struct packed {
    logic                    valid;
    logic                    hit;
    logic [OPBUF_DATA_W-1:0] data;
  } type_opbuf_rd_resp;
  function automatic int rr_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/eu_opbuf_alloc.sv
// eu_opbuf_alloc: round-robin write arbitration with duplicate filtering and free-slot assignment
module eu_opbuf_alloc
  import eu_opbuf_mc_pkg::*;
#(
  parameter int NUM_IDX_BITS = OPBUF_NUM_IDX_BITS,
  parameter int NUM_WR_CH = OPBUF_NUM_WR_CH,
  parameter int ADDR_W = OPBUF_ADDR_W,
  localparam int DEPTH = 2 ** NUM_IDX_BITS,
  localparam int RR_W = rr_bits(NUM_WR_CH)
) (
  input  logic [NUM_WR_CH-1:0]              wr_valid,
  input  logic [NUM_WR_CH*ADDR_W-1:0]       wr_addr,
  input  logic [DEPTH-1:0]                  valid,
  input  logic [DEPTH*ADDR_W-1:0]           tags,
  input  logic [RR_W-1:0]                   rr_ptr,
  output logic [NUM_WR_CH-1:0]              grant,
  output logic [NUM_WR_CH*NUM_IDX_BITS-1:0] slot,
  output logic [RR_W-1:0]                   rr_nxt
);
  logic [DEPTH-1:0] used;
  logic keep, found;
  int ch, hi, n_grant, n_free;
  always_comb begin
    grant = '0;
    slot = '0;
    rr_nxt = rr_ptr;
    used = '0;
    keep = 1'b0;
    found = 1'b0;
    ch = 0;
    hi = 0;
    n_grant = 0;
    n_free = DEPTH - $countones(valid);
    for (int r = 0; r < NUM_WR_CH; r++) begin
      ch = (int'(rr_ptr) + r) % NUM_WR_CH;
      keep = wr_valid[ch];
      for (int e = 0; e < DEPTH; e++)
        if (valid[e] && tags[e*ADDR_W +: ADDR_W] == wr_addr[ch*ADDR_W +: ADDR_W]) keep = 1'b0;
      for (int q = 0; q < NUM_WR_CH; q++) begin
        hi = (int'(rr_ptr) + q) % NUM_WR_CH;
        if (q < r && wr_valid[hi] && wr_addr[hi*ADDR_W +: ADDR_W] == wr_addr[ch*ADDR_W +: ADDR_W]) keep = 1'b0;
      end
      if (keep && n_grant < n_free) begin
        found = 1'b0;
        for (int e = 0; e < DEPTH; e++)
          if (!found && !valid[e] && !used[e]) begin
            found = 1'b1;
            used[e] = 1'b1;
            slot[ch*NUM_IDX_BITS +: NUM_IDX_BITS] = NUM_IDX_BITS'(e);
          end
        grant[ch] = 1'b1;
        n_grant = n_grant + 1;
        rr_nxt = RR_W'((ch + 1) % NUM_WR_CH);
      end
    end
  end
endmodule

// File: rtl/eu_opbuf_mc.sv
// eu_opbuf_mc: multi-channel address-tagged operand receive buffer with CAM lookup
module eu_opbuf_mc
  import eu_opbuf_mc_pkg::*;
#(
  parameter int NUM_IDX_BITS = OPBUF_NUM_IDX_BITS,
  parameter int NUM_WR_CH = OPBUF_NUM_WR_CH,
  parameter int NUM_RD_CH = OPBUF_NUM_RD_CH,
  parameter int ADDR_W = OPBUF_ADDR_W,
  parameter int DATA_W = OPBUF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_WR_CH-1:0]        wr_valid,
  input  logic [NUM_WR_CH*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR_CH*DATA_W-1:0] wr_data,
  output logic [NUM_WR_CH-1:0]        wr_success,
  input  logic [NUM_RD_CH-1:0]        rd_req_valid,
  input  logic [NUM_RD_CH*ADDR_W-1:0] rd_req_addr,
  input  logic [NUM_RD_CH-1:0]        rd_req_consume,
  output logic [NUM_RD_CH-1:0]        rd_resp_valid,
  output logic [NUM_RD_CH-1:0]        rd_resp_hit,
  output logic [NUM_RD_CH*DATA_W-1:0] rd_resp_data,
  output logic [NUM_IDX_BITS:0]       occupancy,
  output logic                        full,
  output logic                        empty
);
  localparam int DEPTH = 2 ** NUM_IDX_BITS;
  localparam int RR_W = rr_bits(NUM_WR_CH);
  logic [DEPTH-1:0] valid, set_mask, clr_mask;
  logic [DEPTH*ADDR_W-1:0] tags;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [RR_W-1:0] rr_ptr, rr_nxt;
  logic [NUM_WR_CH-1:0] grant;
  logic [NUM_WR_CH*NUM_IDX_BITS-1:0] slot;
  logic [NUM_RD_CH-1:0] hit;
  logic [NUM_RD_CH*DATA_W-1:0] hit_data;
  logic dup_tag;
  eu_opbuf_alloc #(
    .NUM_IDX_BITS(NUM_IDX_BITS),
    .NUM_WR_CH(NUM_WR_CH),
    .ADDR_W(ADDR_W)
  ) u_alloc (
    .wr_valid(wr_valid & {NUM_WR_CH{reset_n}}),
    .wr_addr(wr_addr),
    .valid(valid),
    .tags(tags),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .slot(slot),
    .rr_nxt(rr_nxt)
  );
  assign wr_success = grant;
  assign full = occupancy == (NUM_IDX_BITS+1)'(DEPTH);
  assign empty = occupancy == '0;
  always_comb begin
    set_mask = '0;
    for (int c = 0; c < NUM_WR_CH; c++)
      if (grant[c]) set_mask[slot[c*NUM_IDX_BITS +: NUM_IDX_BITS]] = 1'b1;
  end
  always_comb begin
    clr_mask = '0;
    hit = '0;
    hit_data = '0;
    for (int r = 0; r < NUM_RD_CH; r++)
      for (int e = 0; e < DEPTH; e++)
        if (rd_req_valid[r] && valid[e] && tags[e*ADDR_W +: ADDR_W] == rd_req_addr[r*ADDR_W +: ADDR_W]) begin
          hit[r] = 1'b1;
          hit_data[r*DATA_W +: DATA_W] = data_q[e];
          if (rd_req_consume[r]) clr_mask[e] = 1'b1;
        end
  end
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (valid[i] && valid[j] && tags[i*ADDR_W +: ADDR_W] == tags[j*ADDR_W +: ADDR_W]) dup_tag = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
      rr_ptr <= '0;
      rd_resp_valid <= '0;
      rd_resp_hit <= '0;
      rd_resp_data <= '0;
      occupancy <= '0;
    end else begin
      valid <= (valid & ~clr_mask) | set_mask;
      rr_ptr <= rr_nxt;
      rd_resp_valid <= rd_req_valid;
      rd_resp_hit <= hit;
      rd_resp_data <= hit_data;
      occupancy <= (NUM_IDX_BITS+1)'($countones((valid & ~clr_mask) | set_mask));
    end
  end
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_WR_CH; c++)
      if (grant[c]) begin
        tags[int'(slot[c*NUM_IDX_BITS +: NUM_IDX_BITS])*ADDR_W +: ADDR_W] <= wr_addr[c*ADDR_W +: ADDR_W];
        data_q[slot[c*NUM_IDX_BITS +: NUM_IDX_BITS]] <= wr_data[c*DATA_W +: DATA_W];
      end
  end
  assert property (@(posedge clk) disable iff (!reset_n) !dup_tag);
endmodule

// File: tb/tb_eu_opbuf_mc.sv
// tb_eu_opbuf_mc: directed and randomized checks of eu_opbuf_mc against a behavioural model
module tb_eu_opbuf_mc;
  import eu_opbuf_mc_pkg::*;
  localparam int IW = 3, DEPTH = 8, NW = 2, NR = 2, AW = 8, DW = 32;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NW-1:0] wr_valid, wr_success;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR-1:0] rd_req_valid, rd_req_consume, rd_resp_valid, rd_resp_hit;
  logic [NR*AW-1:0] rd_req_addr;
  logic [NR*DW-1:0] rd_resp_data;
  logic [IW:0] occupancy;
  logic full, empty;
  eu_opbuf_mc dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_success(wr_success),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_consume(rd_req_consume),
    .rd_resp_valid(rd_resp_valid), .rd_resp_hit(rd_resp_hit), .rd_resp_data(rd_resp_data),
    .occupancy(occupancy), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  logic wv[NW];
  logic [AW-1:0] wa[NW];
  logic [DW-1:0] wd[NW];
  logic rv[NR];
  logic [AW-1:0] ra[NR];
  logic rc[NR];
  logic rst_n;
  type_opbuf_entry m[DEPTH];
  int rr;
  logic [NW-1:0] exp_succ, got_succ;
  logic [NR-1:0] exp_rv, exp_hit, got_rv, got_hit;
  logic [NR*DW-1:0] exp_data, got_data;
  int exp_occ;
  logic [IW:0] got_occ;
  logic got_full, got_empty;
  int total = 0, bad = 0;
  function automatic int find(input logic [AW-1:0] a);
    for (int e = 0; e < DEPTH; e++) if (m[e].valid && m[e].addr == a) return e;
    return -1;
  endfunction
  task automatic idle();
    for (int c = 0; c < NW; c++) begin wv[c] = 1'b0; wa[c] = '0; wd[c] = '0; end
    for (int r = 0; r < NR; r++) begin rv[r] = 1'b0; ra[r] = '0; rc[r] = 1'b0; end
  endtask
  task automatic tick();
    int free, ng, ch, idx, s;
    int gq[$];
    logic [AW-1:0] seen[$];
    logic dup;
    logic cons[DEPTH];
    logic used[DEPTH];
    for (int c = 0; c < NW; c++) begin
      wr_valid[c] = wv[c]; wr_addr[c*AW +: AW] = wa[c]; wr_data[c*DW +: DW] = wd[c];
    end
    for (int r = 0; r < NR; r++) begin
      rd_req_valid[r] = rv[r]; rd_req_addr[r*AW +: AW] = ra[r]; rd_req_consume[r] = rc[r];
    end
    reset_n = rst_n;
    exp_succ = '0; exp_rv = '0; exp_hit = '0; exp_data = '0; ng = 0; free = 0;
    for (int e = 0; e < DEPTH; e++) begin
      if (!m[e].valid) free++;
      cons[e] = 1'b0; used[e] = 1'b0;
    end
    if (rst_n) begin
      for (int r = 0; r < NW; r++) begin
        ch = (rr + r) % NW;
        if (wv[ch]) begin
          dup = find(wa[ch]) >= 0;
          foreach (seen[i]) if (seen[i] == wa[ch]) dup = 1'b1;
          seen.push_back(wa[ch]);
          if (!dup && ng < free) begin exp_succ[ch] = 1'b1; ng++; gq.push_back(ch); end
        end
      end
      for (int r = 0; r < NR; r++) if (rv[r]) begin
        exp_rv[r] = 1'b1;
        idx = find(ra[r]);
        if (idx >= 0) begin
          exp_hit[r] = 1'b1; exp_data[r*DW +: DW] = m[idx].data;
          if (rc[r]) cons[idx] = 1'b1;
        end
      end
    end
    #1 got_succ = wr_success;
    @(posedge clk);
    #1;
    got_rv = rd_resp_valid; got_hit = rd_resp_hit; got_data = rd_resp_data;
    got_occ = occupancy; got_full = full; got_empty = empty;
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) m[e] = '0;
      rr = 0;
    end else begin
      int slots[$];
      foreach (gq[i]) begin
        s = -1;
        for (int e = 0; e < DEPTH; e++) if (s < 0 && !m[e].valid && !used[e]) s = e;
        used[s] = 1'b1; slots.push_back(s);
      end
      for (int e = 0; e < DEPTH; e++) if (cons[e]) m[e].valid = 1'b0;
      foreach (gq[i]) m[slots[i]] = '{valid: 1'b1, addr: wa[gq[i]], data: wd[gq[i]]};
      if (gq.size() > 0) rr = (gq[gq.size()-1] + 1) % NW;
    end
    exp_occ = 0;
    for (int e = 0; e < DEPTH; e++) if (m[e].valid) exp_occ++;
    @(negedge clk);
  endtask
  task automatic do_reset();
    idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    wv[0] = 1'b1; wa[0] = 8'h11; wd[0] = $urandom; wv[1] = 1'b1; wa[1] = AW'($urandom_range(0, 15)); wd[1] = $urandom;
    tick();
    repeat (2) begin
      idle(); wv[1] = 1'b1; wa[1] = AW'($urandom_range(32, 47)); wd[1] = $urandom;
      rv[1] = 1'b1; ra[1] = AW'($urandom_range(32, 47)); rc[1] = 1'($urandom_range(0, 1));
      tick();
    end
    idle(); wv[0] = 1'b1; wa[0] = 8'h12; rv[0] = 1'b1; ra[0] = 8'h11; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (got_succ !== 2'b00) begin bad++; $display("FAIL reset_succ got=%b exp=00", got_succ); end
    total++; if ({got_occ, got_full, got_empty} !== {4'd0, 1'b0, 1'b1}) begin bad++; $display("FAIL reset_occ got occ=%0d full=%b empty=%b exp 0/0/1", got_occ, got_full, got_empty); end
    total++; if ({got_rv, got_hit, got_data} !== '0) begin bad++; $display("FAIL reset_resp got v=%b h=%b d=%h exp 0", got_rv, got_hit, got_data); end
    idle(); rv[0] = 1'b1; ra[0] = 8'h11; tick();
    total++; if ({got_rv, got_hit, got_data[31:0]} !== {2'b01, 2'b00, 32'h0}) begin bad++; $display("FAIL reset_lookup got v=%b h=%b d=%h exp v=01 h=00 d=0", got_rv, got_hit, got_data[31:0]); end
  endtask
  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle();
      for (int c = 0; c < NW; c++) begin wv[c] = 1'b1; wa[c] = AW'(2*k + c); wd[c] = $urandom; end
      tick();
      total++; if (got_succ !== 2'b11) begin bad++; $display("FAIL fill_succ k=%0d got=%b exp=11", k, got_succ); end
    end
    total++; if ({got_occ, got_full, got_empty} !== {4'd8, 1'b1, 1'b0}) begin bad++; $display("FAIL fill_full got occ=%0d full=%b empty=%b exp 8/1/0", got_occ, got_full, got_empty); end
    idle(); wv[0] = 1'b1; wa[0] = 8'h08; tick();
    total++; if (got_succ !== 2'b00) begin bad++; $display("FAIL full_reject got=%b exp=00", got_succ); end
    idle(); wv[0] = 1'b1; wa[0] = 8'h08; rv[0] = 1'b1; ra[0] = 8'h03; rc[0] = 1'b1; tick();
    total++; if ({got_succ, got_hit, got_occ} !== {2'b00, 2'b01, 4'd7}) begin bad++; $display("FAIL consume_noreuse got succ=%b hit=%b occ=%0d exp 00/01/7", got_succ, got_hit, got_occ); end
    idle(); wv[0] = 1'b1; wa[0] = 8'h08; wd[0] = 32'h0808_0808; tick();
    total++; if (got_succ !== 2'b01) begin bad++; $display("FAIL refill_succ got=%b exp=01", got_succ); end
    total++; if ({dut.valid, dut.tags[3*AW +: AW]} !== {8'hFF, 8'h08}) begin bad++; $display("FAIL refill_slot got valid=%h tag3=%h exp ff/08", dut.valid, dut.tags[3*AW +: AW]); end
  endtask
  task automatic test_rr();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      for (int c = 0; c < NW; c++) begin wv[c] = 1'b1; wa[c] = AW'(8'h40 + 2*k + c); wd[c] = $urandom; end
      tick();
    end
    idle(); wv[1] = 1'b1; wa[1] = 8'h46; tick();
    total++; if (got_occ !== 4'd7) begin bad++; $display("FAIL rr_occ got=%0d exp=7", got_occ); end
    idle(); wv[0] = 1'b1; wa[0] = 8'h50; wv[1] = 1'b1; wa[1] = 8'h51; tick();
    total++; if (got_succ !== 2'b01) begin bad++; $display("FAIL rr_first got=%b exp=01", got_succ); end
    idle(); rv[0] = 1'b1; ra[0] = 8'h40; rc[0] = 1'b1; tick();
    idle(); wv[0] = 1'b1; wa[0] = 8'h52; wv[1] = 1'b1; wa[1] = 8'h51; tick();
    total++; if ({got_succ, got_full} !== {2'b10, 1'b1}) begin bad++; $display("FAIL rr_second got succ=%b full=%b exp 10/1", got_succ, got_full); end
  endtask
  task automatic test_dup();
    do_reset();
    wv[0] = 1'b1; wa[0] = 8'h2A; wd[0] = 32'hA0A0_0001; wv[1] = 1'b1; wa[1] = 8'h2A; wd[1] = 32'hB0B0_0002; tick();
    total++; if ({got_succ, got_occ} !== {2'b01, 4'd1}) begin bad++; $display("FAIL dup_same got succ=%b occ=%0d exp 01/1", got_succ, got_occ); end
    idle(); wv[1] = 1'b1; wa[1] = 8'h2A; tick();
    total++; if ({got_succ, got_occ} !== {2'b00, 4'd1}) begin bad++; $display("FAIL dup_rewrite got succ=%b occ=%0d exp 00/1", got_succ, got_occ); end
    idle(); wv[0] = 1'b1; wa[0] = 8'h2B; wv[1] = 1'b1; wa[1] = 8'h2B; rv[0] = 1'b1; ra[0] = 8'h2A; tick();
    total++; if (got_succ !== 2'b10) begin bad++; $display("FAIL dup_rr got=%b exp=10", got_succ); end
    total++; if ({got_hit[0], got_data[31:0]} !== {1'b1, 32'hA0A0_0001}) begin bad++; $display("FAIL dup_data got h=%b d=%h exp 1/a0a00001", got_hit[0], got_data[31:0]); end
  endtask
  task automatic test_lookup();
    do_reset();
    wv[0] = 1'b1; wa[0] = 8'h05; wd[0] = 32'hDEAD_BEEF; rv[0] = 1'b1; ra[0] = 8'h05; tick();
    total++; if ({got_rv[0], got_hit[0], got_data[31:0]} !== {1'b1, 1'b0, 32'h0}) begin bad++; $display("FAIL lookup_same got v=%b h=%b d=%h exp 1/0/0", got_rv[0], got_hit[0], got_data[31:0]); end
    idle(); rv[0] = 1'b1; ra[0] = 8'h05; rc[0] = 1'b1; tick();
    total++; if ({got_rv[0], got_hit[0], got_data[31:0]} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin bad++; $display("FAIL lookup_hit got v=%b h=%b d=%h exp 1/1/deadbeef", got_rv[0], got_hit[0], got_data[31:0]); end
    idle(); rv[0] = 1'b1; ra[0] = 8'h05; tick();
    total++; if ({got_hit[0], got_data[31:0], got_occ, got_empty} !== {1'b0, 32'h0, 4'd0, 1'b1}) begin bad++; $display("FAIL lookup_after got h=%b d=%h occ=%0d empty=%b exp 0/0/0/1", got_hit[0], got_data[31:0], got_occ, got_empty); end
    idle(); tick();
    total++; if ({got_rv, got_data} !== '0) begin bad++; $display("FAIL lookup_idle got v=%b d=%h exp 0", got_rv, got_data); end
  endtask
  task automatic test_dual();
    do_reset();
    wv[0] = 1'b1; wa[0] = 8'h05; wd[0] = 32'hCAFE_F00D; wv[1] = 1'b1; wa[1] = 8'h06; wd[1] = 32'h1234_5678; tick();
    idle(); rv[0] = 1'b1; ra[0] = 8'h05; rc[0] = 1'b1; rv[1] = 1'b1; ra[1] = 8'h05; rc[1] = 1'b1; tick();
    total++; if ({got_hit, got_data} !== {2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D}) begin bad++; $display("FAIL dual_hit got h=%b d=%h exp 11/cafef00d x2", got_hit, got_data); end
    total++; if (got_occ !== 4'd1) begin bad++; $display("FAIL dual_occ got=%0d exp=1", got_occ); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst_n = $urandom_range(0, 63) != 0;
      for (int c = 0; c < NW; c++) begin
        wv[c] = 1'($urandom_range(0, 1)); wa[c] = AW'($urandom_range(0, 11)); wd[c] = $urandom;
      end
      for (int r = 0; r < NR; r++) begin
        rv[r] = 1'($urandom_range(0, 1)); ra[r] = AW'($urandom_range(0, 11)); rc[r] = 1'($urandom_range(0, 1));
      end
      tick();
      total++; if (got_succ !== exp_succ) begin bad++; $display("FAIL rnd_succ i=%0d got=%b exp=%b", i, got_succ, exp_succ); end
      total++; if ({got_rv, got_hit, got_data} !== {exp_rv, exp_hit, exp_data}) begin bad++; $display("FAIL rnd_resp i=%0d got v=%b h=%b d=%h exp v=%b h=%b d=%h", i, got_rv, got_hit, got_data, exp_rv, exp_hit, exp_data); end
      total++; if ({got_occ, got_full, got_empty} !== {(IW+1)'(exp_occ), exp_occ == DEPTH, exp_occ == 0}) begin bad++; $display("FAIL rnd_occ i=%0d got occ=%0d full=%b empty=%b exp occ=%0d", i, got_occ, got_full, got_empty, exp_occ); end
    end
    rst_n = 1'b1;
  endtask
  initial begin
    idle();
    rst_n = 1'b0;
    rr = 0;
    for (int e = 0; e < DEPTH; e++) m[e] = '0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_fill();
    test_rr();
    test_dup();
    test_lookup();
    test_dual();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
